// File: rtl/ch0_echo_detect.sv
// Channel-0 ultrasonic echo detector. It blanks transmit crosstalk, confirms an echo after
// HOLD_COUNT consecutive above-threshold samples, and reports time of flight and peak magnitude.
module ch0_echo_detect #(
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter int unsigned HOLD_COUNT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] thresh,
  input  logic        start,
  input  logic        ack,
  input  logic        sample_valid,
  input  logic [23:0] sample_data,
  output logic        busy,
  output logic        done,
  output logic        hit,
  output logic [31:0] tof,
  output logic [23:0] peak
);

  typedef enum logic [2:0] {S_IDLE, S_BLANK, S_ARMED, S_CONFIRM, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  run_q, run_d;
  logic [23:0] thr_q, thr_d;
  logic [23:0] peak_q, peak_d;
  logic [31:0] tof_q, tof_d;
  logic        hit_q, hit_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [23:0] mag;
  logic        above;
  logic        busy_now;
  logic        live;
  logic        hit_evt;

  always_comb begin
    // The most negative code has no positive twin, so it clamps to full scale.
    if (sample_data == 24'h800000)
      mag = 24'h7FFFFF;
    else if (sample_data[23])
      mag = ~sample_data + 24'd1;
    else
      mag = sample_data;
    above    = sample_valid && (mag >= thr_q);
    busy_now = (state_q == S_BLANK) || (state_q == S_ARMED) || (state_q == S_CONFIRM);
    live     = (state_q == S_ARMED) || (state_q == S_CONFIRM);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    thr_d   = thr_q;
    peak_d  = peak_q;
    tof_d   = tof_q;
    hit_d   = hit_q;
    hit_evt = 1'b0;

    if (busy_now && (cnt_q != 32'hFFFF_FFFF))
      cnt_d = cnt_q + 32'd1;

    case (state_q)
      S_BLANK: begin
        if (cnt_d == 32'(BLANK_CYCLES))
          state_d = S_ARMED;
      end
      S_ARMED: begin
        if (above) begin
          tof_d = cnt_q;
          run_d = 8'd1;
          if (HOLD_COUNT == 1)
            hit_evt = 1'b1;
          else
            state_d = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (above) begin
          run_d = run_q + 8'd1;
          if ((run_q + 8'd1) == 8'(HOLD_COUNT))
            hit_evt = 1'b1;
        end else if (sample_valid) begin
          run_d   = 8'd0;
          state_d = S_ARMED;
        end
      end
      S_DONE: begin
        if (ack)
          state_d = S_IDLE;
      end
      default: state_d = state_q;
    endcase

    if (live && sample_valid && (mag > peak_q))
      peak_d = mag;

    // A confirming sample in the timeout cycle still counts as a hit.
    if (hit_evt) begin
      state_d = S_DONE;
      hit_d   = 1'b1;
    end else if (busy_now && (cnt_d == 32'(TIMEOUT_CYCLES))) begin
      state_d = S_DONE;
      hit_d   = 1'b0;
      tof_d   = 32'hFFFF_FFFF;
    end

    if (start) begin
      state_d = (BLANK_CYCLES == 0) ? S_ARMED : S_BLANK;
      cnt_d   = 32'd0;
      run_d   = 8'd0;
      thr_d   = thresh;
      peak_d  = 24'd0;
      tof_d   = 32'd0;
      hit_d   = 1'b0;
    end

    busy_d = (state_d == S_BLANK) || (state_d == S_ARMED) || (state_d == S_CONFIRM);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      run_q   <= 8'd0;
      thr_q   <= 24'd0;
      peak_q  <= 24'd0;
      tof_q   <= 32'd0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      thr_q   <= thr_d;
      peak_q  <= peak_d;
      tof_q   <= tof_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hit  = hit_q;
  assign tof  = tof_q;
  assign peak = peak_q;

endmodule

// File: tb/tb_ch0_echo_detect.sv
// Directed bench for ch0_echo_detect with BLANK=4, HOLD=3, TIMEOUT=100.
// The cycle index after the start edge equals the DUT cycle counter.
module tb_ch0_echo_detect;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] thresh = 24'd0;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_data = 24'd0;
  logic        busy, done, hit;
  logic [31:0] tof;
  logic [23:0] peak;

  int n_err = 0;
  int n_chk = 0;

  ch0_echo_detect #(.BLANK_CYCLES(4), .HOLD_COUNT(3), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset_n(reset_n), .thresh(thresh), .start(start), .ack(ack),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .busy(busy), .done(done), .hit(hit), .tof(tof), .peak(peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [23:0] d);
    sample_valid = v;
    sample_data  = d;
    step();
  endtask

  task automatic do_start(input logic [23:0] thr);
    thresh = thr;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    logic seen;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tof",  tof, 32'd0);
    chk("rst_peak", 32'(peak), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Continuous 2000 samples; threshold changes after start must not matter.
    do_start(24'd1000);
    thresh = 24'd5000;
    chk("a_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) feed(1'b1, 24'd2000);
    chk("a_done_early", 32'(done), 32'd0);
    feed(1'b1, 24'd2000);
    chk("a_done", 32'(done), 32'd1);
    chk("a_busy_off", 32'(busy), 32'd0);
    chk("a_tof", tof, 32'd4);
    chk("a_hit", 32'(hit), 32'd1);
    chk("a_peak", 32'(peak), 32'd2000);
    feed(1'b1, 24'd9000);
    chk("a_hold_peak", 32'(peak), 32'd2000);
    do_ack();
    chk("a_ack_done", 32'(done), 32'd0);
    chk("a_ack_busy", 32'(busy), 32'd0);
    chk("a_ack_tof", tof, 32'd4);

    // Run broken by a below sample; ack during BLANK is ignored.
    do_start(24'd1000);
    ack = 1'b1;
    feed(1'b0, 24'd0);
    ack = 1'b0;
    chk("b_ack_ign", 32'(busy), 32'd1);
    for (int k = 1; k < 10; k++) feed(1'b0, 24'd0);
    feed(1'b1, 24'd1500);
    feed(1'b1, 24'd500);
    feed(1'b1, 24'd1500);
    feed(1'b1, 24'd1500);
    chk("b_done_early", 32'(done), 32'd0);
    feed(1'b1, 24'd1500);
    chk("b_done", 32'(done), 32'd1);
    chk("b_tof", tof, 32'd12);
    chk("b_hit", 32'(hit), 32'd1);
    chk("b_peak", 32'(peak), 32'd1500);
    do_ack();

    // Timeout with all samples below threshold.
    do_start(24'd1000);
    for (int k = 0; k < 99; k++) feed(1'b1, 24'd200);
    chk("c_done_early", 32'(done), 32'd0);
    feed(1'b1, 24'd200);
    chk("c_done", 32'(done), 32'd1);
    chk("c_hit", 32'(hit), 32'd0);
    chk("c_tof", tof, 32'hFFFF_FFFF);
    chk("c_peak", 32'(peak), 32'd200);
    do_ack();

    // The most negative sample saturates to full scale and meets a full-scale threshold.
    do_start(24'h7FFFFF);
    for (int k = 0; k < 7; k++) feed(1'b1, 24'h800000);
    chk("d_done", 32'(done), 32'd1);
    chk("d_hit", 32'(hit), 32'd1);
    chk("d_tof", tof, 32'd4);
    chk("d_peak", 32'(peak), 32'h7FFFFF);

    // Zero threshold: a zero-valued sample counts as above. Start is accepted from DONE.
    do_start(24'd0);
    for (int k = 0; k < 7; k++) feed(1'b1, 24'd0);
    chk("e_done", 32'(done), 32'd1);
    chk("e_hit", 32'(hit), 32'd1);
    chk("e_tof", tof, 32'd4);

    // A threshold above full scale is unreachable, so the measurement times out.
    do_start(24'h800000);
    for (int k = 0; k < 100; k++) feed(1'b1, 24'h800000);
    chk("f_done", 32'(done), 32'd1);
    chk("f_hit", 32'(hit), 32'd0);
    chk("f_tof", tof, 32'hFFFF_FFFF);
    chk("f_peak", 32'(peak), 32'h7FFFFF);

    // A restart at counter 20 while in CONFIRM clears the run and the results.
    do_start(24'd1000);
    for (int k = 0; k < 19; k++) feed(1'b0, 24'd0);
    feed(1'b1, 24'd2000);
    sample_valid = 1'b1;
    sample_data  = 24'd2000;
    do_start(24'd1000);
    chk("g_busy", 32'(busy), 32'd1);
    chk("g_done", 32'(done), 32'd0);
    chk("g_tof", tof, 32'd0);
    chk("g_peak", 32'(peak), 32'd0);
    for (int k = 0; k < 6; k++) feed(1'b1, 24'd2000);
    chk("g_done_early", 32'(done), 32'd0);
    feed(1'b1, 24'd2000);
    chk("g_done2", 32'(done), 32'd1);
    chk("g_tof2", tof, 32'd4);
    // Start and ack together in DONE: start takes priority.
    sample_valid = 1'b0;
    start = 1'b1;
    ack   = 1'b1;
    step();
    start = 1'b0;
    ack   = 1'b0;
    chk("h_done", 32'(done), 32'd0);
    chk("h_busy", 32'(busy), 32'd1);
    chk("h_hit", 32'(hit), 32'd0);

    // An asynchronous reset at counter 30 discards the measurement.
    for (int k = 0; k < 30; k++) feed(1'b1, 24'd200);
    chk("i_peak_pre", 32'(peak), 32'd200);
    #2;
    reset_n = 1'b0;
    #1;
    chk("i_busy", 32'(busy), 32'd0);
    chk("i_done", 32'(done), 32'd0);
    chk("i_peak", 32'(peak), 32'd0);
    chk("i_tof", tof, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 150; k++) begin
      feed(1'b1, 24'd200);
      seen = seen | done | busy;
    end
    chk("i_no_done", 32'(seen), 32'd0);
    do_start(24'd1000);
    for (int k = 0; k < 7; k++) feed(1'b1, 24'd2000);
    chk("i_after_done", 32'(done), 32'd1);
    chk("i_after_tof", tof, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ch0_echo_detect.md
CH0_ECHO_DETECT -- requirements
Module: ch0_echo_detect

Interface
REQ-001 Parameter BLANK_CYCLES, default 1000: clock cycles after start during which samples are ignored (transmit crosstalk blanking).
REQ-002 Parameter HOLD_COUNT, default 4: consecutive above-threshold valid samples needed to confirm an echo; legal range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: cycles after start after which the measurement ends with no hit; SHALL be > BLANK_CYCLES.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 thresh  in  24  unsigned magnitude threshold, driven from the CH0 threshold PIO out_port.
REQ-007 start  in  1  one-cycle pulse marking ultrasonic burst launch.
REQ-008 ack  in  1  one-cycle pulse from software clearing a completed result.
REQ-009 sample_valid  in  1  qualifies sample_data for the current cycle.
REQ-010 sample_data  in  24  signed two's-complement ADC sample, channel 0.
REQ-011 busy  out  1  high in BLANK, ARMED and CONFIRM states.
REQ-012 done  out  1  high in DONE state.
REQ-013 hit  out  1  valid while done; 1 = echo confirmed, 0 = timeout.
REQ-014 tof  out  32  cycle count from start to first sample of the confirmed run; 0xFFFFFFFF on timeout.
REQ-015 peak  out  24  largest sample magnitude seen in ARMED/CONFIRM during the current measurement.

Function
REQ-016 States IDLE, BLANK, ARMED, CONFIRM, DONE; all outputs registered.
REQ-017 Magnitude = |sample_data|; -8388608 saturates to 0x7FFFFF; sample "above" when magnitude >= latched threshold.
REQ-018 thresh latched into an internal register on the edge that accepts start; changes to thresh during a measurement have no effect.
REQ-019 start high in any state: cycle counter cleared to 0, run counter, peak, hit cleared, tof = 0, state -> BLANK on that edge (restart aborts any measurement in progress).
REQ-020 Cycle counter increments by 1 every cycle while busy; saturates at 0xFFFFFFFF.
REQ-021 BLANK -> ARMED on the edge at which the counter reaches BLANK_CYCLES; samples in BLANK are ignored entirely (no peak, no run).
REQ-022 ARMED: valid above sample -> record tof = counter value in that cycle, run = 1; go to CONFIRM, or directly to DONE with hit=1 if HOLD_COUNT = 1.
REQ-023 CONFIRM: valid above sample increments run; on run reaching HOLD_COUNT -> DONE, hit=1; valid below sample -> run = 0, ARMED; cycles with sample_valid low leave run unchanged.
REQ-024 peak updates on every valid sample in ARMED/CONFIRM whose magnitude exceeds current peak.
REQ-025 Timeout: counter reaching TIMEOUT_CYCLES in BLANK/ARMED/CONFIRM -> DONE, hit=0, tof = 0xFFFFFFFF; if a confirming sample occurs in the same cycle, the hit takes priority.
REQ-026 done rises the cycle after the confirming sample or timeout; DONE holds tof/hit/peak stable until ack or start.
REQ-027 ack in DONE -> IDLE; ack in other states ignored; start and ack together -> start wins.
REQ-028 Threshold 0: first valid sample in ARMED counts as above; latched threshold > 0x7FFFFF: no hit possible, measurement ends by timeout.

Reset
REQ-029 reset_n low asynchronously forces IDLE, busy=0, done=0, hit=0, tof=0, peak=0, all counters and latched threshold to 0; reset mid-measurement discards it, no done pulse.

Verification (bench parameters BLANK_CYCLES=4, HOLD_COUNT=3, TIMEOUT_CYCLES=100)
REQ-030 thresh=1000, start, valid samples 2000 continuously from counter 0 -> samples in cycles 0..3 ignored, done rises after counter 6, tof=4, hit=1, peak=2000.
REQ-031 thresh=1000, samples 1500,500,1500,1500,1500 from counter 10 -> run resets on 500, tof=12, hit=1.
REQ-032 thresh=1000, all samples 200 -> done at counter 100, hit=0, tof=0xFFFFFFFF, peak=200.
REQ-033 Sample -8388608, thresh=0x7FFFFF -> magnitude 0x7FFFFF counts as above, peak=0x7FFFFF.
REQ-034 start at counter 20 mid-CONFIRM -> counter restarts at 0, run cleared; start+ack together in DONE -> new measurement, done=0, busy=1.
REQ-035 reset_n low at counter 30 -> all outputs 0 immediately; no done after reset_n returns high until a new start.
